// File: rtl/bmst_llr_pkg.sv
// Shared constants and helpers for the BMST-NBLDPC LLR datapath.
// Lanes are packed side by side; lane c starts at bit c*(WIDTH+1).
package bmst_llr_pkg;

   localparam int LLR_WIDTH    = 5;
   localparam int LLR_CHANNELS = 4;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int lane_lo(input int c, input int width);
      return c * (width + 1);
   endfunction

endpackage

// File: rtl/llr_stage_reg.sv
// One delay-line stage: a packed LLR vector plus its valid bit.
// Priority per edge is reset_n, then clear, then the active-low advance.
module llr_stage_reg
   import bmst_llr_pkg::*;
#(
   parameter int W = LLR_CHANNELS * (LLR_WIDTH + 1)
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         Enable_n,
   input  logic         clear,
   input  logic [W-1:0] d,
   input  logic         dv,
   output logic [W-1:0] q,
   output logic         qv
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q  <= '0;
         qv <= 1'b0;
      end else if (clear) begin
         q  <= '0;
         qv <= 1'b0;
      end else if (!Enable_n) begin
         q  <= d;
         qv <= dv;
      end
   end

endmodule

// File: rtl/llr_tap_delay_line.sv
// Multi-lane LLR delay line with per-stage valid, run-time output tap,
// synchronous flush and a running count of valid stages.
module llr_tap_delay_line
   import bmst_llr_pkg::*;
#(
   parameter  int WIDTH    = LLR_WIDTH,
   parameter  int CHANNELS = LLR_CHANNELS,
   parameter  int DEPTH    = 8,
   localparam int SEL_W    = clog2(DEPTH + 1),
   localparam int VEC_W    = CHANNELS * (WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             Enable_n,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [VEC_W-1:0] in_data,
   input  logic [SEL_W-1:0] delay_sel,
   output logic             out_valid,
   output logic [VEC_W-1:0] out_data,
   output logic [SEL_W-1:0] fill_count,
   output logic             delay_err
);

   localparam logic [SEL_W-1:0] DEPTH_S = SEL_W'(DEPTH);

   logic [VEC_W-1:0] stage_data [DEPTH];
   logic             stage_v    [DEPTH];
   logic [SEL_W-1:0] tap_idx;
   logic [SEL_W-1:0] fill_q;
   logic [SEL_W-1:0] v_count;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic [VEC_W-1:0] d_in;
      logic             dv_in;

      if (k == 0) begin : g_head
         assign d_in  = in_data;
         assign dv_in = in_valid;
      end else begin : g_body
         assign d_in  = stage_data[k-1];
         assign dv_in = stage_v[k-1];
      end

      llr_stage_reg #(.W(VEC_W)) u_stage (
         .clk      (clk),
         .reset_n  (reset_n),
         .Enable_n (Enable_n),
         .clear    (clear),
         .d        (d_in),
         .dv       (dv_in),
         .q        (stage_data[k]),
         .qv       (stage_v[k])
      );
   end

   // Out-of-range selects fall back to the deepest tap.
   assign delay_err = (delay_sel == '0) || (delay_sel > DEPTH_S);
   assign tap_idx   = delay_err ? (DEPTH_S - SEL_W'(1)) : (delay_sel - SEL_W'(1));

   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (tap_idx == SEL_W'(k)) begin
            out_valid = stage_v[k];
            out_data  = stage_v[k] ? stage_data[k] : '0;
         end
      end
   end

   // Entering and leaving samples on the same advance cancel out.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fill_q <= '0;
      end else if (clear) begin
         fill_q <= '0;
      end else if (!Enable_n) begin
         fill_q <= fill_q + SEL_W'(in_valid) - SEL_W'(stage_v[DEPTH-1]);
      end
   end

   assign fill_count = fill_q;

   always_comb begin
      v_count = '0;
      for (int k = 0; k < DEPTH; k++) begin
         v_count = v_count + SEL_W'(stage_v[k]);
      end
   end

   fill_matches_popcount: assert property (@(posedge clk) disable iff (!reset_n)
      fill_q == v_count);

endmodule

// File: tb/tb_llr_tap_delay_line.sv
// Self-checking bench for llr_tap_delay_line (DEPTH=8, 4 lanes of 6 bits).
module tb_llr_tap_delay_line;
   import bmst_llr_pkg::*;

   localparam int WIDTH    = 5;
   localparam int CHANNELS = 4;
   localparam int DEPTH    = 8;
   localparam int SEL_W    = 4;
   localparam int VEC_W    = CHANNELS * (WIDTH + 1);

   localparam logic [VEC_W-1:0] D1 = 24'hA5A51F;
   localparam logic [VEC_W-1:0] D2 = 24'h33330A;
   localparam logic [VEC_W-1:0] D3 = 24'hC3C321;
   localparam logic [VEC_W-1:0] D4 = 24'h0C0C04;
   localparam logic [VEC_W-1:0] D5 = 24'h2A2A2A;
   localparam logic [VEC_W-1:0] D6 = 24'h151515;
   localparam logic [VEC_W-1:0] JA = 24'hFFFFFF;
   localparam logic [VEC_W-1:0] JB = 24'h111111;
   localparam logic [VEC_W-1:0] JC = 24'h3F3F3F;
   localparam logic [VEC_W-1:0] Z  = 24'h000000;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             Enable_n;
   logic             clear;
   logic             in_valid;
   logic [VEC_W-1:0] in_data;
   logic [SEL_W-1:0] delay_sel;
   logic             out_valid;
   logic [VEC_W-1:0] out_data;
   logic [SEL_W-1:0] fill_count;
   logic             delay_err;

   int errors = 0;
   int checks = 0;
   logic [VEC_W-1:0] sb_q [$];

   typedef struct {
      logic             en_n;
      logic             clr;
      logic             iv;
      logic [VEC_W-1:0] d;
      logic [SEL_W-1:0] sel;
      logic             ev;
      logic [VEC_W-1:0] ed;
      logic [SEL_W-1:0] ef;
      logic             ee;
   } vec_t;

   vec_t tbl [18];

   llr_tap_delay_line #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .Enable_n   (Enable_n),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .delay_sel  (delay_sel),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .fill_count (fill_count),
      .delay_err  (delay_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [VEC_W-1:0] vec_of(input int i);
      logic [VEC_W-1:0] v;
      v = '0;
      for (int c = 0; c < CHANNELS; c++)
         v[lane_lo(c, WIDTH) +: WIDTH+1] = 6'((i + 7 * c) & 63);
      return v;
   endfunction

   function automatic vec_t mk(input int en_n, input int clr, input int iv,
                               input logic [VEC_W-1:0] d, input int sel,
                               input int ev, input logic [VEC_W-1:0] ed,
                               input int ef, input int ee);
      vec_t r;
      r.en_n = 1'(en_n);
      r.clr  = 1'(clr);
      r.iv   = 1'(iv);
      r.d    = d;
      r.sel  = SEL_W'(sel);
      r.ev   = 1'(ev);
      r.ed   = ed;
      r.ef   = SEL_W'(ef);
      r.ee   = 1'(ee);
      return r;
   endfunction

   task automatic step(input logic en_n, input logic clr, input logic iv, input logic [VEC_W-1:0] d);
      Enable_n = en_n;
      clear    = clr;
      in_valid = iv;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic ev, input logic [VEC_W-1:0] ed, input int ef);
      check({tag, " out_valid"}, 32'(out_valid), 32'(ev));
      check({tag, " out_data"}, 32'(out_data), 32'(ed));
      check({tag, " fill_count"}, 32'(fill_count), 32'(ef));
   endtask

   // Continuous valid stream at a fixed tap; expected samples queued on drive.
   task automatic stream(input int n, input int sel, input string tag);
      int adv;
      logic [VEC_W-1:0] v;
      logic [VEC_W-1:0] exp_d;
      adv = 0;
      sb_q.delete();
      delay_sel = SEL_W'(sel);
      for (int i = 1; i <= n; i++) begin
         v = vec_of(i);
         sb_q.push_back(v);
         step(1'b0, 1'b0, 1'b1, v);
         adv++;
         if (adv >= sel) begin
            exp_d = sb_q.pop_front();
            check_out($sformatf("%s adv%0d", tag, adv), 1'b1, exp_d, (adv > DEPTH) ? DEPTH : adv);
         end else begin
            check_out($sformatf("%s adv%0d", tag, adv), 1'b0, Z, adv);
         end
      end
   endtask

   initial begin
      reset_n   = 1'b1;
      Enable_n  = 1'b1;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      delay_sel = SEL_W'(3);

      tbl[0]  = mk(0, 1, 1, JC, 1, 0, Z,  0, 0);
      tbl[1]  = mk(0, 0, 1, D1, 1, 1, D1, 1, 0);
      tbl[2]  = mk(0, 0, 0, D2, 1, 0, Z,  1, 0);
      tbl[3]  = mk(0, 0, 1, D3, 1, 1, D3, 2, 0);
      tbl[4]  = mk(1, 0, 1, JA, 3, 1, D1, 2, 0);
      tbl[5]  = mk(1, 0, 1, JA, 2, 0, Z,  2, 0);
      tbl[6]  = mk(0, 0, 1, D4, 2, 1, D3, 3, 0);
      tbl[7]  = mk(0, 0, 0, JB, 5, 1, D1, 3, 0);
      tbl[8]  = mk(0, 0, 0, JB, 0, 0, Z,  3, 1);
      tbl[9]  = mk(0, 0, 0, JB, 9, 0, Z,  3, 1);
      tbl[10] = mk(0, 0, 0, JB, 9, 1, D1, 3, 1);
      tbl[11] = mk(1, 0, 0, JB, 8, 1, D1, 3, 0);
      tbl[12] = mk(0, 0, 1, D5, 8, 0, Z,  3, 0);
      tbl[13] = mk(0, 0, 1, D6, 7, 1, D4, 4, 0);
      tbl[14] = mk(0, 1, 1, JC, 1, 0, Z,  0, 0);
      tbl[15] = mk(1, 0, 0, Z,  8, 0, Z,  0, 0);
      tbl[16] = mk(0, 0, 1, D1, 1, 1, D1, 1, 0);
      tbl[17] = mk(1, 1, 0, Z,  1, 0, Z,  0, 0);

      // Power-up reset
      #1 reset_n = 1'b0;
      #1;
      check_out("reset", 1'b0, Z, 0);
      check("reset delay_err", 32'(delay_err), 32'(0));
      @(posedge clk);
      @(posedge clk);
      #3 reset_n = 1'b1;

      stream(20, 3, "fixed");

      for (int i = 0; i < 18; i++) begin
         delay_sel = tbl[i].sel;
         step(tbl[i].en_n, tbl[i].clr, tbl[i].iv, tbl[i].d);
         check_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].ed, 32'(tbl[i].ef));
         check($sformatf("row%0d delay_err", i), 32'(delay_err), 32'(tbl[i].ee));
      end

      // Stall: one advance, five holds, then the sample emerges on the next advance
      delay_sel = SEL_W'(2);
      step(1'b0, 1'b1, 1'b0, Z);
      check_out("stall clear", 1'b0, Z, 0);
      step(1'b0, 1'b0, 1'b1, vec_of(40));
      check_out("stall adv1", 1'b0, Z, 1);
      for (int h = 0; h < 5; h++) begin
         step(1'b1, 1'b0, 1'b1, JA);
         check_out($sformatf("stall hold%0d", h), 1'b0, Z, 1);
      end
      step(1'b0, 1'b0, 1'b0, JB);
      check_out("stall adv2", 1'b1, vec_of(40), 1);
      step(1'b0, 1'b0, 1'b0, JB);
      check_out("stall adv3", 1'b0, Z, 1);

      // Reset mid-stream, observed between edges
      delay_sel = SEL_W'(3);
      step(1'b0, 1'b1, 1'b0, Z);
      step(1'b0, 1'b0, 1'b1, vec_of(50));
      step(1'b0, 1'b0, 1'b1, vec_of(51));
      step(1'b0, 1'b0, 1'b1, vec_of(52));
      check_out("pre_rst", 1'b1, vec_of(50), 3);
      Enable_n = 1'b1;
      reset_n  = 1'b0;
      #1;
      check_out("mid_rst", 1'b0, Z, 0);
      #2 reset_n = 1'b1;
      stream(6, 3, "post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
